// File: rtl/io_dec_pkg.sv
// Shared constants for the I/O strobe decoder: FSM state encodings and
// the widths of the strobe and timeout down-counters.
package io_dec_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  // Wide enough for STROBE_CYC-1 (max 14) and TIMEOUT-1 (max 254).
  localparam int STB_CNT_W = 4;
  localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/io_strobe_timer.sv
// Loadable down-counter with a zero flag. Load wins over decrement; the
// count saturates at zero so a stray decrement cannot wrap.
module io_strobe_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, decrement toward zero, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/io_strobe_decoder.sv
// I/O strobe decoder: decodes the top address bits into a one-hot device
// select and sequences IDLE -> STROBE -> (WAIT) -> ACK -> IDLE.
// Optional feature macro: IO_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and
// reports the expiry on io_err alongside io_ack.
//
// Handshake: io_req is a request level sampled only in IDLE; once taken,
// the transaction always ends with exactly one io_ack pulse, and io_busy is
// high from the first STROBE cycle through the ACK cycle. A request still
// high during ACK is taken in the IDLE cycle that follows.
module io_strobe_decoder
  import io_dec_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int NDEV       = 4,
  parameter int STROBE_CYC = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [NDEV-1:0]   dev_wait,
  output logic [NDEV-1:0]   dev_wr,
  output logic [NDEV-1:0]   dev_rd,
  output logic              io_busy,
  output logic              io_ack,
  output logic              io_err,
  output logic [1:0]        dbg_state_o
);

  localparam int SEL_W = $clog2(NDEV);
  localparam logic [STB_CNT_W-1:0] STB_LOAD = STB_CNT_W'(STROBE_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             we_q, we_d;
  logic [NDEV-1:0]  dev_wr_q, dev_wr_d;
  logic [NDEV-1:0]  dev_rd_q, dev_rd_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [NDEV-1:0]  sel_oh;
  logic             wait_sel;
  logic             stb_load, stb_dec, stb_zero;
  logic             unused_addr;

  // Only the top SEL_W address bits select a device.
  assign unused_addr = ^io_addr[ADDR_W-SEL_W-1:0];

  // Only the selected device's wait request steers the sequence.
  assign wait_sel = dev_wait[sel_q];

  io_strobe_timer #(.W(STB_CNT_W)) u_stb_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (stb_load),
    .load_val_i (STB_LOAD),
    .dec_i      (stb_dec),
    .zero_o     (stb_zero)
  );

`ifdef IO_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LOAD = TMO_CNT_W'(TIMEOUT - 1);
  logic tmo_load, tmo_dec, tmo_zero;

  io_strobe_timer #(.W(TMO_CNT_W)) u_tmo_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .dec_i      (tmo_dec),
    .zero_o     (tmo_zero)
  );
`endif

  // Next state, latched request fields and timer controls.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    err_d    = 1'b0;
    stb_load = 1'b0;
    stb_dec  = 1'b0;
`ifdef IO_TIMEOUT_EN
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (io_req) begin
          sel_d    = io_addr[ADDR_W-1 -: SEL_W];
          we_d     = io_we;
          stb_load = 1'b1;
          state_d  = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (stb_zero) begin
          if (!wait_sel) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
`ifdef IO_TIMEOUT_EN
            tmo_load = 1'b1;
`endif
          end
        end else begin
          stb_dec = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!wait_sel) begin
          state_d = ST_ACK;
`ifdef IO_TIMEOUT_EN
        end else if (tmo_zero) begin
          // This is the TIMEOUT-th WAIT cycle and the device still stalls.
          state_d = ST_ACK;
          err_d   = 1'b1;
        end else begin
          tmo_dec = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_d] = 1'b1;
    dev_wr_d = ((state_d == ST_STROBE) && we_d) ? sel_oh : '0;
    dev_rd_d = (((state_d == ST_STROBE) || (state_d == ST_WAIT)) && !we_d) ? sel_oh : '0;
    busy_d   = (state_d != ST_IDLE);
    ack_d    = (state_d == ST_ACK);
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      we_q     <= 1'b0;
      dev_wr_q <= '0;
      dev_rd_q <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      dev_wr_q <= dev_wr_d;
      dev_rd_q <= dev_rd_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign dev_wr      = dev_wr_q;
  assign dev_rd      = dev_rd_q;
  assign io_busy     = busy_q;
  assign io_ack      = ack_q;
  assign io_err      = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_strobe_decoder.sv
// Self-checking bench for io_strobe_decoder (NDEV=4, ADDR_W=12,
// STROBE_CYC=2, TIMEOUT=15). Expected per-cycle output vectors
// {busy, ack, err, wr[3:0], rd[3:0]} are queued when a transaction is
// driven and popped as each cycle's outputs are sampled.
module tb_io_strobe_decoder;

  localparam int ADDR_W  = 12;
  localparam int NDEV    = 4;
  localparam int STB     = 2;
  localparam int TMO     = 15;
  localparam int VW      = 11;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              io_req = 1'b0;
  logic              io_we = 1'b0;
  logic [ADDR_W-1:0] io_addr = '0;
  logic [NDEV-1:0]   dev_wait = '0;
  logic [NDEV-1:0]   dev_wr, dev_rd;
  logic              io_busy, io_ack, io_err;
  logic [1:0]        dbg_state;

  io_strobe_decoder #(
    .ADDR_W(ADDR_W), .NDEV(NDEV), .STROBE_CYC(STB), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_req(io_req), .io_we(io_we),
    .io_addr(io_addr), .dev_wait(dev_wait), .dev_wr(dev_wr),
    .dev_rd(dev_rd), .io_busy(io_busy), .io_ack(io_ack), .io_err(io_err),
    .dbg_state_o(dbg_state)
  );

  // Scoreboard.
  logic [VW-1:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_vec(input string tag, input logic [VW-1:0] got,
                           input logic [VW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] obs();
    return {io_busy, io_ack, io_err, dev_wr, dev_rd};
  endfunction

  // One transaction. Entered at posedge+1 of the cycle used as cycle 0,
  // returns at posedge+1 of the cycle after ACK. w = number of cycles
  // dev_wait[sel] stays high after the strobe; hold keeps io_req high;
  // abort_c >= 0 pulses reset in that cycle instead of finishing.
  task automatic run_txn(input logic [ADDR_W-1:0] addr, input bit we,
                         input int w, input bit hold, input int abort_c);
    logic [1:0]      sel;
    logic [NDEV-1:0] oh;
    int              nw;
    bit              to;
    int              ack_c;
    logic [VW-1:0]   v;
    sel = addr[ADDR_W-1 -: 2];
    oh  = 4'b0001 << sel;
    nw  = w;
    to  = 1'b0;
`ifdef IO_TIMEOUT_EN
    if (w >= TMO) begin
      nw = TMO;
      to = 1'b1;
    end
`endif
    ack_c = STB + nw + 1;
    for (int c = 0; c <= ack_c; c++) begin
      if (c == 0)
        v = '0;
      else if (c <= STB)
        v = {1'b1, 1'b0, 1'b0, (we ? oh : 4'b0), (we ? 4'b0 : oh)};
      else if (c < ack_c)
        v = {1'b1, 1'b0, 1'b0, 4'b0, (we ? 4'b0 : oh)};
      else
        v = {1'b1, 1'b1, to, 4'b0, 4'b0};
      exp_q.push_back(v);
    end
    for (int c = 0; c <= ack_c; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c == abort_c) begin
        #1 rst_n = 1'b0;
        #1;
        check_vec("async_reset_out", obs(), '0);
        check_vec("async_reset_state", {9'b0, dbg_state}, '0);
        exp_q.delete();
        io_req   = 1'b0;
        dev_wait = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      check_vec($sformatf("addr%h_c%0d", addr, c), obs(), exp_q.pop_front());
      if (c == 0) begin
        io_addr = addr;
        io_we   = we;
      end
      io_req   = (c == 0) || hold;
      dev_wait = 4'($urandom_range(0, 15));
      dev_wait[sel] = (w > 0) && (c >= STB) && (c < STB + w);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_out", obs(), '0);
    check_vec("reset_state", {9'b0, dbg_state}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_txn(12'h8A5, 1'b1, 0, 1'b0, -1);   // write, no wait
    run_txn(12'hC00, 1'b0, 3, 1'b0, -1);   // read, 3 wait cycles
    run_txn(12'h123, 1'b1, 2, 1'b0, -1);   // write with wait
    run_txn(12'h400, 1'b0, 0, 1'b1, -1);   // io_req held high
    run_txn(12'h7FF, 1'b1, 0, 1'b1, -1);
    run_txn(12'hBCD, 1'b0, 1, 1'b0, -1);
    run_txn(12'hC00, 1'b0, 5, 1'b0, 4);    // reset in WAIT
    run_txn(12'h8A5, 1'b1, 0, 1'b0, -1);   // recovers normally
    run_txn(12'h400, 1'b0, 20, 1'b0, -1);  // long stall / timeout
    for (int i = 0; i < 6; i++) begin
      run_txn(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
